// File: rtl/pw_conv_engine.sv
// Pointwise (1x1) convolution for one output pixel: NUM_LANES output channels in parallel,
// each doing INT8 MAC, bias add, optional LeakyReLU and requantization to INT8.
module pw_conv_engine #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned CIN_MAX   = 512,
    parameter int unsigned SCALE_Q   = 16,
    parameter int unsigned CIN_W     = $clog2(CIN_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CIN_W-1:0]       cfg_cin,
    input  logic                   cfg_leaky_en,
    input  logic [15:0]            cfg_scale,
    input  logic [NUM_LANES*32-1:0] bias_in,
    input  logic                   act_valid,
    output logic                   act_ready,
    input  logic [7:0]             act_data,
    input  logic [NUM_LANES*8-1:0] w_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_LANES*8-1:0] out_data,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {StIdle, StAccum, StLeaky, StReq, StOut} state_e;

    localparam logic [CIN_W-1:0]   CinMaxC = CIN_W'(CIN_MAX);
    localparam logic signed [47:0] RoundC  = 48'sd1 <<< (SCALE_Q - 1);

    state_e state_q, state_d;

    logic [CIN_W-1:0]  cin_q, cnt_q, cnt_inc, cin_clamped;
    logic              leaky_q;
    logic [15:0]       scale_q;
    logic signed [31:0] bias_q [NUM_LANES];
    logic signed [31:0] acc_q  [NUM_LANES];
    logic signed [31:0] y_q    [NUM_LANES];
    logic [NUM_LANES*8-1:0] out_q;

    logic signed [15:0] prod  [NUM_LANES];
    logic signed [31:0] acc_d [NUM_LANES];
    logic signed [31:0] sum   [NUM_LANES];
    logic signed [31:0] y_d   [NUM_LANES];
    logic signed [47:0] scaled[NUM_LANES];
    logic signed [47:0] rq    [NUM_LANES];
    logic [NUM_LANES*8-1:0] out_d;
    logic beat;

    assign cin_clamped = (cfg_cin > CinMaxC) ? CinMaxC : cfg_cin;
    assign cnt_inc     = cnt_q + CIN_W'(1);
    assign beat        = act_valid && (state_q == StAccum);
    assign out_data    = out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        act_ready = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (cin_clamped == '0) ? StLeaky : StAccum;
                end
            end
            StAccum: begin
                act_ready = 1'b1;
                if (beat && (cnt_inc == cin_q)) begin
                    state_d = StLeaky;
                end
            end
            StLeaky: state_d = StReq;
            StReq:   state_d = StOut;
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Per-lane datapath; the scale is zero-extended so it always multiplies as positive.
    always_comb begin
        out_d = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            prod[k]   = 16'($signed(act_data)) * 16'($signed(w_data[8*k +: 8]));
            acc_d[k]  = acc_q[k] + 32'(prod[k]);
            sum[k]    = acc_q[k] + bias_q[k];
            y_d[k]    = (leaky_q && sum[k][31]) ? (sum[k] >>> 3) : sum[k];
            scaled[k] = 48'(y_q[k]) * 48'($signed({1'b0, scale_q}));
            rq[k]     = (scaled[k] + RoundC) >>> SCALE_Q;
            if (rq[k] > 48'sd127) begin
                out_d[8*k +: 8] = 8'h7F;
            end else if (rq[k] < -48'sd128) begin
                out_d[8*k +: 8] = 8'h80;
            end else begin
                out_d[8*k +: 8] = rq[k][7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cin_q   <= '0;
            cnt_q   <= '0;
            leaky_q <= 1'b0;
            scale_q <= '0;
            out_q   <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                bias_q[k] <= '0;
                acc_q[k]  <= '0;
                y_q[k]    <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cin_q   <= cin_clamped;
                        cnt_q   <= '0;
                        leaky_q <= cfg_leaky_en;
                        scale_q <= cfg_scale;
                        for (int k = 0; k < NUM_LANES; k++) begin
                            bias_q[k] <= bias_in[32*k +: 32];
                            acc_q[k]  <= '0;
                        end
                    end
                end
                StAccum: begin
                    if (beat) begin
                        cnt_q <= cnt_inc;
                        for (int k = 0; k < NUM_LANES; k++) begin
                            acc_q[k] <= acc_d[k];
                        end
                    end
                end
                StLeaky: begin
                    for (int k = 0; k < NUM_LANES; k++) begin
                        y_q[k] <= y_d[k];
                    end
                end
                StReq:   out_q <= out_d;
                StOut:   ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pw_conv_engine.sv
// Directed self-checking bench for pw_conv_engine with hand-computed expected results.
module tb_pw_conv_engine;

    localparam int unsigned NL    = 4;
    localparam int unsigned CIN_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CIN_W-1:0] cfg_cin = '0;
    logic             cfg_leaky_en = 1'b0;
    logic [15:0]      cfg_scale = '0;
    logic [NL*32-1:0] bias_in = '0;
    logic             act_valid = 1'b0;
    logic             act_ready;
    logic [7:0]       act_data = '0;
    logic [NL*8-1:0]  w_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [NL*8-1:0]  out_data;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_pass   = 0;
    logic ready_seen;

    pw_conv_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_cin      (cfg_cin),
        .cfg_leaky_en (cfg_leaky_en),
        .cfg_scale    (cfg_scale),
        .bias_in      (bias_in),
        .act_valid    (act_valid),
        .act_ready    (act_ready),
        .act_data     (act_data),
        .w_data       (w_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      tag, $signed(got), got, $signed(exp), exp);
    endtask

    function automatic logic [31:0] lane(input int k);
        return 32'($signed(out_data[8*k +: 8]));
    endfunction

    task automatic check_lanes(input string tag, input int e0, input int e1, input int e2,
                               input int e3);
        check({tag, "_l0"}, lane(0), e0);
        check({tag, "_l1"}, lane(1), e1);
        check({tag, "_l2"}, lane(2), e2);
        check({tag, "_l3"}, lane(3), e3);
    endtask

    // Drives start for one cycle; returns #1 after the edge that samples it.
    task automatic start_job(input int cin, input bit leaky, input int scale,
                             input logic [NL*32-1:0] bias);
        @(posedge clk); #1;
        start = 1'b1;
        cfg_cin = CIN_W'(cin);
        cfg_leaky_en = leaky;
        cfg_scale = 16'(scale);
        bias_in = bias;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Edge count is relative to the edge before start was driven.
    task automatic wait_out(input string tag, input int exp_edges);
        int n = 1;
        ready_seen = act_ready;
        while (!out_valid && n < 2000) begin
            @(posedge clk); #1;
            n++;
            ready_seen = ready_seen | act_ready;
        end
        check({tag, "_lat"}, n, exp_edges);
    endtask

    task automatic handshake(input string tag);
        check({tag, "_done_lo"}, done, 0);
        out_ready = 1'b1;
        #1;
        check({tag, "_done_hi"}, done, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_valid_after"}, out_valid, 0);
        check({tag, "_done_after"}, done, 0);
    endtask

    task automatic run_basic(input string tag);
        act_data = 8'd1;
        w_data = 32'h0100FE02;
        act_valid = 1'b1;
        start_job(4, 1'b1, 32768, '0);
        wait_out(tag, 7);
        check_lanes(tag, 4, 0, 0, 2);
        handshake(tag);
        act_valid = 1'b0;
    endtask

    initial begin
        int beats;
        int guard;
        int n;

        #1;
        check("rst_act_ready", act_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_basic("basic");

        // Saturation, linear and leaky.
        act_data = 8'h7F;
        w_data = 32'h0000807F;
        act_valid = 1'b1;
        start_job(4, 1'b0, 32768, '0);
        wait_out("sat_lin", 7);
        check_lanes("sat_lin", 127, -128, 0, 0);
        handshake("sat_lin");
        start_job(4, 1'b1, 32768, '0);
        wait_out("sat_lky", 7);
        check_lanes("sat_lky", 127, -128, 0, 0);
        handshake("sat_lky");

        // Zero-length: bias only, act_valid held high but never consumed.
        start_job(0, 1'b1, 65535, {64'h0, 32'hFFFFFFB0, 32'h00000064});
        wait_out("zlen", 3);
        check("zlen_ready_seen", ready_seen, 0);
        check_lanes("zlen", 100, -10, 0, 0);
        handshake("zlen");

        // cfg_cin above the maximum runs CIN_MAX beats: 512/256 -> 2, unclamped would give 4.
        act_data = 8'd1;
        w_data = 32'h00000001;
        start_job(1023, 1'b0, 256, '0);
        wait_out("clamp", 515);
        check_lanes("clamp", 2, 0, 0, 0);
        handshake("clamp");

        // 128 beats with random gaps, then backpressure.
        w_data = 32'h0002FF01;
        act_valid = 1'b0;
        start_job(128, 1'b1, 32768, {32'hFFFFFC18, 96'h0});
        beats = 0;
        guard = 0;
        while (beats < 128 && guard < 2000) begin
            act_valid = ($urandom_range(0, 2) != 0);
            if (act_valid && act_ready) beats++;
            @(posedge clk); #1;
            guard++;
        end
        check("stall_beats", beats, 128);
        act_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_lat", n, 2);
        for (int i = 0; i < 5; i++) begin
            check_lanes("bp", 64, -8, 127, -62);
            check("bp_valid", out_valid, 1);
            check("bp_act_ready", act_ready, 0);
            check("bp_done", done, 0);
            @(posedge clk); #1;
        end
        handshake("bp");
        act_valid = 1'b0;

        // Reset in the middle of accumulation.
        act_data = 8'd3;
        w_data = 32'h05050505;
        act_valid = 1'b1;
        start_job(16, 1'b0, 65535, '0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_act_ready", act_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        act_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_basic("post_rst");

        // start while busy must change nothing.
        act_data = 8'd1;
        w_data = 32'h0100FE02;
        act_valid = 1'b0;
        start_job(4, 1'b1, 32768, '0);
        start = 1'b1;
        cfg_cin = '0;
        cfg_leaky_en = 1'b0;
        cfg_scale = 16'hFFFF;
        bias_in = {4{32'd1000}};
        @(posedge clk); #1;
        start = 1'b0;
        act_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        act_valid = 1'b0;
        check("ign_valid", out_valid, 1);
        check_lanes("ign", 4, 0, 0, 2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_out_hold", out_valid, 1);
        handshake("ign");
        repeat (4) @(posedge clk);
        #1;
        check("ign_no_extra_busy", busy, 0);
        check("ign_no_extra_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
